// File: rtl/spi_master_cfg.sv
// Parametrised full-duplex SPI master: configurable width/divider/chip selects, per-frame CPOL/CPHA.
// Define SPI_MSB_FIRST_EN for MSB-first wire order; the default build shifts LSB first.
module spi_master_cfg #(
    parameter int DATA_W  = 12,
    parameter int CLK_DIV = 10,
    parameter int NUM_CS  = 2,
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HP_W  = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HP_W-1:0]    hp_q, hp_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic [NUM_CS-1:0]  cs_q, cs_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               done_q, done_d;
    logic               cpol_q, cpol_d;
    logic               cpha_q, cpha_d;

    // Wire-order helpers: the only place the two builds differ.
    logic               first_bit, next_bit;
    logic [DATA_W-1:0]  tx_load, tx_next, rx_next;
`ifdef SPI_MSB_FIRST_EN
    assign first_bit = din[DATA_W-1];
    assign tx_load   = din << 1;
    assign next_bit  = tx_q[DATA_W-1];
    assign tx_next   = tx_q << 1;
    assign rx_next   = {rx_q[DATA_W-2:0], miso};
`else
    assign first_bit = din[0];
    assign tx_load   = din >> 1;
    assign next_bit  = tx_q[0];
    assign tx_next   = tx_q >> 1;
    assign rx_next   = {miso, rx_q[DATA_W-1:1]};
`endif

    // Out-of-range selects decode to no asserted chip select.
    logic [NUM_CS-1:0] cs_dec;
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            cs_dec[i] = (int'(cs_sel) != i);
        end
    end

    logic            edge_fire;
    logic [HP_W-1:0] edge_idx;
    logic            edge_lead, edge_sample, edge_shift;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        hp_d      = hp_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        dout_d    = dout_q;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        edge_fire = 1'b0;
        edge_idx  = hp_q;

        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                mosi_d = 1'b0;
                cs_d   = '1;
                cnt_d  = '0;
                hp_d   = '0;
                if (newd) begin
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    cs_d    = cs_dec;
                    mosi_d  = first_bit;
                    tx_d    = tx_load;
                    rx_d    = '0;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    state_d   = XFER;
                    edge_fire = 1'b1;
                    edge_idx  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            XFER: begin
                // Each half-period opens with an sclk edge; the last one closes back at cpol.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (hp_q == HP_LAST) begin
                        state_d = TRAIL;
                    end else begin
                        hp_d      = hp_q + 1'b1;
                        edge_fire = 1'b1;
                        edge_idx  = hp_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TRAIL: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    cs_d    = '1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    dout_d  = rx_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Even edges lead; CPHA picks whether leading or trailing edges sample.
        edge_lead   = ~edge_idx[0];
        edge_sample = edge_lead ^ cpha_q;
        edge_shift  = ~edge_sample && (edge_idx != '0) && (edge_idx != HP_LAST);
        if (edge_fire) begin
            sclk_d = ~sclk_q;
            if (edge_sample) begin
                rx_d = rx_next;
            end
            if (edge_shift) begin
                mosi_d = next_bit;
                tx_d   = tx_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hp_q    <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            cs_q    <= '1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign dout  = dout_q;
    assign sclk  = sclk_q;
    assign mosi  = mosi_q;
    assign cs    = cs_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg (DATA_W=12, CLK_DIV=10, NUM_CS=2): frame table plus
// back-to-back, ignored-request and mid-frame reset sequences against a behavioural SPI slave.
module tb_spi_master_cfg;

    localparam int DW    = 12;
    localparam int DIV   = 10;
    localparam int NCS   = 2;
    localparam int FRAME = DIV * (2 * DW + 2) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          newd = 1'b0;
    logic [DW-1:0] din = '0;
    logic [0:0]    cs_sel = '0;
    logic          cpol = 1'b0;
    logic          cpha = 1'b0;
    logic          ready, done, sclk, mosi, miso;
    logic [DW-1:0] dout;
    logic [NCS-1:0] cs;

    logic          loopback = 1'b1;
    logic [DW-1:0] s_word = '0;
    logic          slave_miso = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    assign miso = loopback ? mosi : slave_miso;

    spi_master_cfg #(.DATA_W(DW), .CLK_DIV(DIV), .NUM_CS(NCS)) dut (
        .clk(clk), .rst(rst), .newd(newd), .din(din), .cs_sel(cs_sel),
        .cpol(cpol), .cpha(cpha), .ready(ready), .done(done), .dout(dout),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs(cs)
    );

    always #5 clk = ~clk;

    // Slave model and wire monitor: resyncs whenever the master is idle.
    logic          prev_sclk = 1'b0;
    logic          s_cpol = 1'b0;
    logic          s_cpha = 1'b0;
    int            s_idx = 0;
    int            lead_cnt = 0;
    logic [DW-1:0] cap = '0;

    function automatic logic slave_bit(input int i);
        if (i >= DW) return 1'b0;
`ifdef SPI_MSB_FIRST_EN
        return s_word[DW-1-i];
`else
        return s_word[i];
`endif
    endfunction

    always @(negedge clk) begin
        logic lead;
        if (ready) begin
            s_cpol     = cpol;
            s_cpha     = cpha;
            s_idx      = 0;
            slave_miso = slave_bit(0);
            prev_sclk  = sclk;
        end else if (sclk != prev_sclk) begin
            lead = (prev_sclk == s_cpol);
            if (lead) lead_cnt++;
            if (lead != s_cpha) begin
`ifdef SPI_MSB_FIRST_EN
                cap = {cap[DW-2:0], mosi};
`else
                cap = {mosi, cap[DW-1:1]};
`endif
            end else if (!s_cpha) begin
                s_idx++;
                slave_miso = slave_bit(s_idx);
            end else begin
                slave_miso = slave_bit(s_idx);
                s_idx++;
            end
            prev_sclk = sclk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          cpol;
        logic          cpha;
        logic [0:0]    sel;
        logic [DW-1:0] din;
        logic [DW-1:0] sword;
        logic          loop;
        logic [DW-1:0] exp_dout;
        logic [NCS-1:0] exp_cs;
    } vec_t;

    function automatic logic first_of(input logic [DW-1:0] w);
`ifdef SPI_MSB_FIRST_EN
        return w[DW-1];
`else
        return w[0];
`endif
    endfunction

    // Applies the vector while idle, accepts it, and leaves the bench at the negedge of T+1.
    task automatic start_frame(input vec_t v);
        @(negedge clk);
        cpol = v.cpol; cpha = v.cpha; cs_sel = v.sel; din = v.din;
        loopback = v.loop; s_word = v.sword;
        @(negedge clk);
        check("idle_sclk_at_cpol", sclk, v.cpol);
        newd = 1'b1;
        @(negedge clk);
        newd = 1'b0;
        check("lead_cs", cs, v.exp_cs);
        check("lead_ready", ready, 1'b0);
        check("lead_first_mosi", mosi, first_of(v.din));
    endtask

    task automatic run_frame(input vec_t v);
        int n, cs_bad, lead0;
        lead0 = lead_cnt;
        start_frame(v);
        n = 1; cs_bad = 0;
        while (!done && n < 400) begin
            if (cs !== v.exp_cs) cs_bad++;
            @(negedge clk);
            n++;
        end
        check("done_latency", n, FRAME);
        check("cs_held_in_frame", cs_bad, 0);
        check("dout", dout, v.exp_dout);
        check("done_cs_released", cs, {NCS{1'b1}});
        check("done_mosi", mosi, 1'b0);
        check("done_ready", ready, 1'b1);
        check("done_sclk_at_cpol", sclk, v.cpol);
        check("leading_edges", lead_cnt - lead0, DW);
        check("mosi_sequence", cap, v.din);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
    endtask

    vec_t vecs[6];

    initial begin
        int n, m, extra, bad;
        vec_t v;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 12'hA5C, 12'h000, 1'b1, 12'hA5C, 2'b10};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 12'h5A3, 12'h3C1, 1'b0, 12'h3C1, 2'b01};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 12'h0F0, 12'h3C1, 1'b0, 12'h3C1, 2'b01};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 12'h924, 12'h3C1, 1'b0, 12'h3C1, 2'b01};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 12'h800, 12'h000, 1'b1, 12'h800, 2'b10};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 12'h001, 12'h000, 1'b1, 12'h001, 2'b10};

        repeat (3) @(negedge clk);
        check("rst_cs", cs, 2'b11);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_ready", ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_dout", dout, 12'h000);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // Back-to-back: newd held through the done cycle.
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; cs_sel = 1'b0; loopback = 1'b1;
        din = 12'h001; newd = 1'b1;
        @(negedge clk);
        din = 12'hFFF;
        n = 1;
        while (!done && n < 400) begin @(negedge clk); n++; end
        check("b2b_first_latency", n, FRAME);
        check("b2b_first_dout", dout, 12'h001);
        check("b2b_gap_cs_high", cs, 2'b11);
        @(negedge clk);
        newd = 1'b0;
        check("b2b_second_cs_low", cs, 2'b10);
        check("b2b_second_ready", ready, 1'b0);
        m = 1;
        while (!done && m < 400) begin @(negedge clk); m++; end
        check("b2b_done_spacing", m, FRAME);
        check("b2b_second_dout", dout, 12'hFFF);

        // Request while busy is dropped.
        v = '{1'b0, 1'b0, 1'b0, 12'h456, 12'h000, 1'b1, 12'h456, 2'b10};
        start_frame(v);
        n = 1;
        repeat (50) begin @(negedge clk); n++; end
        din = 12'h123; newd = 1'b1;
        @(negedge clk); n++;
        newd = 1'b0;
        while (!done && n < 400) begin @(negedge clk); n++; end
        check("busy_newd_latency", n, FRAME);
        check("busy_newd_dout", dout, 12'h456);
        extra = 0; bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (done) extra++;
            if (cs !== 2'b11 || !ready) bad++;
        end
        check("busy_newd_no_extra_done", extra, 0);
        check("busy_newd_stays_idle", bad, 0);

        // Reset 100 cycles into a frame.
        v = '{1'b0, 1'b0, 1'b0, 12'hFFF, 12'h000, 1'b1, 12'hFFF, 2'b10};
        start_frame(v);
        repeat (99) @(negedge clk);
        check("pre_rst_sclk_high", sclk, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("midrst_cs", cs, 2'b11);
        check("midrst_sclk", sclk, 1'b0);
        check("midrst_mosi", mosi, 1'b0);
        check("midrst_ready", ready, 1'b1);
        check("midrst_dout", dout, 12'h000);
        @(negedge clk);
        rst = 1'b1;
        extra = 0;
        repeat (300) begin @(negedge clk); if (done) extra++; end
        check("midrst_no_done", extra, 0);
        check("midrst_dout_kept", dout, 12'h000);
        run_frame(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
